// File: rtl/read_result_2.sv
// Sweeps the FC output-neuron RAM, buffers the fixed-latency read data and streams it out with a running signed argmax.
// Latency: first word out READ_LATENCY+2 cycles after start. Backpressure: reads are issued only while fewer than FIFO_DEPTH words are reserved.

module rr2_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_wr_vld,
  input  logic [WIDTH-1:0] i_wr_dat,
  input  logic             i_rd_rdy,
  output logic             o_rd_vld,
  output logic [WIDTH-1:0] o_rd_dat
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push   = i_wr_vld && (r_count != FULL_CNT);
  assign w_pop    = i_rd_rdy && (r_count != '0);
  assign o_rd_vld = (r_count != '0);
  assign o_rd_dat = r_mem[r_rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wr_dat;
        r_wr_ptr        <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module read_result_2 #(
  parameter int DATA_WIDTH_FC           = 16,
  parameter int FC_OUTNEURON_ADDR_WIDTH = 4,
  parameter int OUTNEURON               = 10,
  parameter int PO                      = 1,
  parameter int READ_LATENCY            = 2,
  parameter int FIFO_DEPTH              = 4
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               start,
  output logic                               busy,
  output logic                               done,
  output logic                               fc_outneuron_rden,
  output logic [FC_OUTNEURON_ADDR_WIDTH-1:0] fc_outneuron_address,
  input  logic [DATA_WIDTH_FC-1:0]           fc_outneuron_q,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_WIDTH_FC-1:0]           out_data,
  output logic [FC_OUTNEURON_ADDR_WIDTH-1:0] out_index,
  output logic [FC_OUTNEURON_ADDR_WIDTH-1:0] argmax_index,
  output logic [DATA_WIDTH_FC-1:0]           argmax_value,
  output logic                               argmax_valid
);
  localparam int DW = DATA_WIDTH_FC;
  localparam int AW = FC_OUTNEURON_ADDR_WIDTH;
  localparam int L  = READ_LATENCY;
  localparam int N  = OUTNEURON / PO;
  localparam int RW = $clog2(FIFO_DEPTH + 1);
  localparam int CW = $clog2(N + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
  localparam logic [RW-1:0] DEPTH_C   = RW'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_CNT  = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t         r_state;
  logic [AW-1:0]  r_addr;
  logic [RW-1:0]  r_reserved;
  logic [CW-1:0]  r_acc_cnt;
  logic           r_busy;
  logic           r_done;
  logic           r_amax_vld;
  logic [AW-1:0]  r_amax_idx;
  logic [DW-1:0]  r_amax_val;
  logic [L-1:0]   r_dl_vld;
  logic [AW-1:0]  r_dl_addr [L];

  logic           w_issue;
  logic           w_accept;
  logic           w_fifo_vld;
  logic [AW+DW-1:0] w_head;
  logic [AW-1:0]  w_head_idx;
  logic [DW-1:0]  w_head_dat;

  // Credit check: reserved already counts reads still travelling through the RAM pipe.
  assign w_issue    = (r_state == S_READ) && (r_reserved < DEPTH_C);
  assign w_accept   = w_fifo_vld && out_ready;
  assign w_head_idx = w_head[AW+DW-1:DW];
  assign w_head_dat = w_head[DW-1:0];

  assign busy                 = r_busy;
  assign done                 = r_done;
  assign fc_outneuron_rden    = w_issue;
  assign fc_outneuron_address = r_addr;
  assign out_valid            = w_fifo_vld;
  assign out_data             = w_head_dat;
  assign out_index            = w_head_idx;
  assign argmax_index         = r_amax_idx;
  assign argmax_value         = r_amax_val;
  assign argmax_valid         = r_amax_vld;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_dl_vld <= '0;
      for (int i = 0; i < L; i++) r_dl_addr[i] <= '0;
    end else begin
      r_dl_vld[0]  <= w_issue;
      r_dl_addr[0] <= r_addr;
      for (int i = 1; i < L; i++) begin
        r_dl_vld[i]  <= r_dl_vld[i-1];
        r_dl_addr[i] <= r_dl_addr[i-1];
      end
    end
  end

  rr2_fifo #(
    .WIDTH (AW + DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .i_wr_vld (r_dl_vld[L-1]),
    .i_wr_dat ({r_dl_addr[L-1], fc_outneuron_q}),
    .i_rd_rdy (out_ready),
    .o_rd_vld (w_fifo_vld),
    .o_rd_dat (w_head)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_reserved <= '0;
      r_acc_cnt  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_amax_vld <= 1'b0;
      r_amax_idx <= '0;
      r_amax_val <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_issue) r_addr <= r_addr + AW'(1);
      case ({w_issue, w_accept})
        2'b10:   r_reserved <= r_reserved + RW'(1);
        2'b01:   r_reserved <= r_reserved - RW'(1);
        default: r_reserved <= r_reserved;
      endcase
      // First word of a sweep seeds the argmax; strict compare keeps the lower index on ties.
      if (w_accept) begin
        r_acc_cnt <= r_acc_cnt + CW'(1);
        if ((r_acc_cnt == '0) || ($signed(w_head_dat) > $signed(r_amax_val))) begin
          r_amax_idx <= w_head_idx;
          r_amax_val <= w_head_dat;
        end
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_READ;
            r_busy     <= 1'b1;
            r_addr     <= '0;
            r_reserved <= '0;
            r_acc_cnt  <= '0;
            r_amax_vld <= 1'b0;
            r_amax_idx <= '0;
            r_amax_val <= '0;
          end
        end
        S_READ: begin
          if (w_issue && (r_addr == LAST_ADDR)) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_accept && (r_acc_cnt == LAST_CNT)) begin
            r_state    <= S_DONE;
            r_done     <= 1'b1;
            r_amax_vld <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_read_result_2.sv
// Bench for read_result_2: directed sweeps plus random RAM contents and random backpressure,
// checked against a queue/array model of the expected stream and argmax.

module tb_read_result_2;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int N  = 10;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start;
  logic          out_ready;
  logic          busy, done, fc_outneuron_rden, out_valid, argmax_valid;
  logic [AW-1:0] fc_outneuron_address, out_index, argmax_index;
  logic [DW-1:0] fc_outneuron_q, out_data, argmax_value;

  logic [DW-1:0] mem [16];
  logic [AW-1:0] ram_a;
  int            n_asrt = 0;
  int            n_fail = 0;

  always #5 clock = ~clock;

  // Two-cycle RAM: registered address, registered output.
  always @(posedge clock) begin
    ram_a          <= fc_outneuron_address;
    fc_outneuron_q <= mem[ram_a];
  end

  read_result_2 #(
    .DATA_WIDTH_FC           (DW),
    .FC_OUTNEURON_ADDR_WIDTH (AW),
    .OUTNEURON               (N),
    .PO                      (1),
    .READ_LATENCY            (2),
    .FIFO_DEPTH              (4)
  ) dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .start                (start),
    .busy                 (busy),
    .done                 (done),
    .fc_outneuron_rden    (fc_outneuron_rden),
    .fc_outneuron_address (fc_outneuron_address),
    .fc_outneuron_q       (fc_outneuron_q),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_data             (out_data),
    .out_index            (out_index),
    .argmax_index         (argmax_index),
    .argmax_value         (argmax_value),
    .argmax_valid         (argmax_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  function automatic int model_amax_idx();
    int best;
    best = 0;
    for (int i = 1; i < N; i++)
      if ($signed(mem[i]) > $signed(mem[best])) best = i;
    return best;
  endfunction

  function automatic logic rdy_for(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c > 20);
      2:       return (c % 2 == 1);
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  // Pulses start in the current cycle (cycle 0) and observes until done; returns in the cycle after done.
  task automatic sweep(input string tag, input int mode, input int xstart, input bit start_in_done);
    int c, issued, acc, first_rden, first_vld, done_c, max_out, addr_err, unstable, pre21, bi;
    logic pv, pr;
    logic [AW-1:0] pi;
    logic [DW-1:0] pd, d20;
    logic [AW-1:0] gi[$];
    logic [DW-1:0] gd[$];
    issued = 0; acc = 0; first_rden = -1; first_vld = -1; done_c = -1;
    max_out = 0; addr_err = 0; unstable = 0; pre21 = 0;
    pv = 1'b0; pr = 1'b0; pi = '0; pd = '0; d20 = '0;
    start = 1'b1;
    step();
    c = 1;
    while (done_c < 0 && c <= 400) begin
      start     = (c == xstart);
      out_ready = rdy_for(mode, c);
      #1;
      if (c == 1) begin
        chk({tag, ".busy_c1"}, 32'(busy), 1);
        chk({tag, ".amax_vld_c1"}, 32'(argmax_valid), 0);
      end
      if (fc_outneuron_rden) begin
        if (first_rden < 0) first_rden = c;
        if (fc_outneuron_address !== AW'(issued)) addr_err++;
        issued++;
        if (c < 21) pre21++;
      end
      if (issued - acc > max_out) max_out = issued - acc;
      if (pv && !pr && (!out_valid || out_data !== pd || out_index !== pi)) unstable++;
      if (c == 20) d20 = out_data;
      if (out_valid && first_vld < 0) first_vld = c;
      if (out_valid && out_ready) begin
        gi.push_back(out_index);
        gd.push_back(out_data);
        acc++;
      end
      pv = out_valid; pr = out_ready; pd = out_data; pi = out_index;
      if (done) begin
        done_c = c;
        start  = start_in_done;
      end else begin
        step();
        c++;
      end
    end
    if (done_c < 0) begin
      chk({tag, ".timeout"}, 0, 1);
      start = 1'b0;
      return;
    end
    bi = model_amax_idx();
    chk({tag, ".first_rden"}, first_rden, 1);
    chk({tag, ".addr_order"}, addr_err, 0);
    chk({tag, ".rsv_le_4"}, 32'(max_out <= 4), 1);
    chk({tag, ".stall_stable"}, unstable, 0);
    chk({tag, ".count"}, gi.size(), N);
    for (int i = 0; i < gi.size() && i < N; i++) begin
      chk($sformatf("%s.idx%0d", tag, i), 32'(gi[i]), i);
      chk($sformatf("%s.dat%0d", tag, i), 32'(gd[i]), 32'(mem[i]));
    end
    chk({tag, ".done_busy"}, 32'(busy), 1);
    chk({tag, ".done_amax_vld"}, 32'(argmax_valid), 1);
    chk({tag, ".amax_idx"}, 32'(argmax_index), bi);
    chk({tag, ".amax_val"}, 32'(argmax_value), 32'(mem[bi]));
    if (mode == 0) begin
      chk({tag, ".first_vld"}, first_vld, 4);
      chk({tag, ".done_cyc"}, done_c, 14);
    end
    if (mode == 1) begin
      chk({tag, ".rden_before21"}, pre21, 4);
      chk({tag, ".held_c20"}, 32'(d20), 32'(mem[0]));
    end
    step();
    start = 1'b0;
    chk({tag, ".post_busy"}, 32'(busy), 0);
    chk({tag, ".post_done"}, 32'(done), 0);
    chk({tag, ".post_amax_vld"}, 32'(argmax_valid), 1);
    chk({tag, ".post_valid"}, 32'(out_valid), 0);
  endtask

  task automatic load_basic();
    int v[N] = '{5, -3, 12, 7, 0, 12, -8, 1, 2, 9};
    for (int i = 0; i < N; i++) mem[i] = 16'(v[i]);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".rden"}, 32'(fc_outneuron_rden), 0);
    chk({tag, ".addr"}, 32'(fc_outneuron_address), 0);
    chk({tag, ".valid"}, 32'(out_valid), 0);
    chk({tag, ".data"}, 32'(out_data), 0);
    chk({tag, ".index"}, 32'(out_index), 0);
    chk({tag, ".amax"}, {argmax_valid, argmax_index, argmax_value}, 0);
  endtask

  initial begin
    int bad;
    reset_n   = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (3) step();
    chk_zero("reset");
    reset_n = 1'b1;
    step();

    load_basic();
    sweep("basic", 0, -1, 1'b0);
    chk("basic.amax_idx_tie", 32'(argmax_index), 2);
    chk("basic.amax_val_12", 32'(argmax_value), 12);
    step();

    sweep("bp", 1, -1, 1'b0);
    step();

    for (int i = 0; i < N; i++) mem[i] = 16'(-(i + 1));
    sweep("neg", 0, -1, 1'b0);
    chk("neg.amax_idx", 32'(argmax_index), 0);
    chk("neg.amax_val", 32'(argmax_value), 32'h0000_ffff);
    step();

    load_basic();
    sweep("toggle", 2, -1, 1'b0);
    step();

    // Starts in cycle 6 and in the done cycle must be ignored; cycle 16 start is taken.
    sweep("restart", 0, 6, 1'b1);
    step();
    sweep("restart2", 0, -1, 1'b0);
    step();

    start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    chk("rst.valid_before", 32'(out_valid), 1);
    reset_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    step();
    step();
    reset_n = 1'b1;
    bad = 0;
    repeat (8) begin
      step();
      if (out_valid || fc_outneuron_rden || busy || done) bad++;
    end
    chk("rst.quiet_after", bad, 0);
    mem[3] = 16'h7fff;
    sweep("rst_sweep", 0, -1, 1'b0);
    step();

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < N; i++)
        mem[i] = (k % 2 == 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 6)) - 3);
      sweep($sformatf("rand%0d", k), 3, -1, 1'b0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/read_result_2.md
# read_result_2

Reader for the FC output-neuron RAM that the FC result writer fills. On a start pulse it sweeps the RAM from address 0 to OUTNEURON/PO-1, absorbs the fixed RAM read latency in a small credit-controlled FIFO, and streams each neuron value out on a valid/ready interface. It also tracks the signed argmax of the streamed values, which the classifier output stage consumes.

## Interface
- DATA_WIDTH_FC, 16, width of one stored neuron word (signed).
- FC_OUTNEURON_ADDR_WIDTH, 4, RAM address width.
- OUTNEURON, 10, number of output neurons.
- PO, 1, neurons per RAM word. Word count N = OUTNEURON/PO.
- READ_LATENCY, 2, cycles from rden/address to valid q. Fixed, registered address and output.
- FIFO_DEPTH, 4, output buffer depth. Must be >= READ_LATENCY+2.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a sweep. Ignored while busy=1.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last word is accepted downstream.
- fc_outneuron_rden  out  1  RAM read enable.
- fc_outneuron_address  out  FC_OUTNEURON_ADDR_WIDTH  RAM read address.
- fc_outneuron_q  in  DATA_WIDTH_FC  RAM read data.
- out_valid  out  1  out_data and out_index are valid.
- out_ready  in  1  downstream accepts the current word.
- out_data  out  DATA_WIDTH_FC  neuron value.
- out_index  out  FC_OUTNEURON_ADDR_WIDTH  address the value came from.
- argmax_index  out  FC_OUTNEURON_ADDR_WIDTH  index of the largest value.
- argmax_value  out  DATA_WIDTH_FC  largest value, signed.
- argmax_valid  out  1  high from the done cycle until the next accepted start.

## Operation
- Reset values: all outputs 0, FIFO empty, FSM in IDLE, counters 0.
- FSM states:
  - IDLE: start=1 goes to READ and clears the issue address, the reserved count, argmax_valid and the argmax registers.
  - READ: issue reads until address N-1 is issued, then go to DRAIN.
  - DRAIN: wait until N words have been accepted, then go to DONE.
  - DONE: one cycle with done=1, argmax_valid set, then back to IDLE.
- Issue rule:
  - rden=1 with the current address when reserved < FIFO_DEPTH.
  - reserved = in-flight reads + FIFO occupancy. It increments on issue and decrements on accept (out_valid & out_ready). Both in the same cycle leave it unchanged.
  - The address increments after each issue and is never issued past N-1. rden=0 in all other cycles.
- Capture: a delay line READ_LATENCY deep tracks rden and address. When its tap is set, fc_outneuron_q and the tagged address are written to the FIFO. The credit rule guarantees the FIFO is never full on a write.
- Output: out_valid = FIFO not empty. out_data and out_index come from the FIFO head and hold stable while out_valid=1 and out_ready=0. Pop on accept.
- Argmax, evaluated on each accept:
  - The first accepted word of a sweep loads the argmax registers unconditionally.
  - Later words replace them only if strictly greater, using a signed compare. Ties keep the lower index.
- Reset deasserted mid-sweep: everything returns to IDLE. In-flight reads are discarded and not captured after reset release.

## Timing
- start is sampled high at the end of cycle 0. busy=1 and the first rden (address 0) occur in cycle 1.
- q for the read issued in cycle n is sampled at the end of cycle n+READ_LATENCY. It enters the FIFO, so out_valid first rises in cycle n+READ_LATENCY+1: cycle 4 with the defaults.
- With out_ready held at 1: one word per cycle, addresses issued in cycles 1–10, words accepted in cycles 4–13, done=1 in cycle 14, busy=0 from cycle 15, argmax_valid=1 from cycle 14.
- Backpressure: with out_ready=0, at most FIFO_DEPTH reads are outstanding. Issue resumes the cycle after the first accept.
- A start pulse arriving in the DONE cycle is ignored. A start in the cycle after DONE is accepted.

## Test plan
- RAM = {5,-3,12,7,0,12,-8,1,2,9}, out_ready=1, start pulse: out_index 0..9 in cycles 4–13 with matching data, done in cycle 14, argmax_index=2, argmax_value=12 (tie at 5 keeps 2).
- Same RAM with out_ready=0 for cycles 1–20, then 1: exactly 4 rden pulses (addresses 0–3) before cycle 21, out_data=5 held stable, then all 10 words in order with no loss or duplicates.
- All-negative RAM {-1,-2,...,-10}: argmax_index=0, argmax_value=-1, proving the signed compare and first-word load.
- out_ready toggling 1,0,1,0: sequence intact and out_data stable on every stalled cycle. reserved never exceeds 4, checked by assertion.
- start pulsed again in cycle 6 and in the DONE cycle: both ignored, with a single done pulse. A start in cycle 16 begins a new sweep and clears argmax_valid in cycle 17.
- reset_n low in cycle 7 for 2 cycles: outputs 0 immediately. No FIFO writes after release. A new start gives a clean full sweep with correct argmax.
